// File: rtl/f_sched_ctl.sv
// BLAKE2 G-function step sequencer: walks sub-steps and rounds for a full
// compression, emitting registered working-vector and sigma message selectors.
module f_sched_ctl #(
    parameter int G_CYCLES = 1,
    parameter int ROUNDS_S = 10,
    parameter int ROUNDS_B = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic       stall,
    output logic       busy,
    output logic       step_valid,
    output logic       step_last,
    output logic [2:0] sub_ctr,
    output logic [3:0] rnd_ctr,
    output logic [3:0] a_sel,
    output logic [3:0] b_sel,
    output logic [3:0] c_sel,
    output logic [3:0] d_sel,
    output logic [3:0] m0_sel,
    output logic [3:0] m1_sel,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] LP_HC_LAST = 2'(G_CYCLES - 1);
    localparam logic [3:0] LP_LAST_S  = 4'(ROUNDS_S - 1);
    localparam logic [3:0] LP_LAST_B  = 4'(ROUNDS_B - 1);

    state_t     r_state;
    logic [1:0] r_hc;
    logic [2:0] r_sub;
    logic [3:0] r_rnd;
    logic       r_mode;

    logic       w_step_end;
    logic       w_final;
    logic [2:0] w_nsub;
    logic [3:0] w_nrnd;
    logic [3:0] w_last_rnd;

    // Columns for sub 0..3, then the four diagonals; packed as {a,b,c,d}.
    function automatic logic [15:0] vec_sel(input logic [2:0] sub);
        case (sub)
            3'd4:    return 16'h05AF;
            3'd5:    return 16'h16BC;
            3'd6:    return 16'h278D;
            3'd7:    return 16'h349E;
            default: return {2'b00, sub[1:0], 2'b01, sub[1:0],
                             2'b10, sub[1:0], 2'b11, sub[1:0]};
        endcase
    endfunction

    // Each row holds sigma[0..15] with element 0 in the top nibble; the byte
    // at pair index sub is {sigma[2*sub], sigma[2*sub+1]} = {m0, m1}.
    function automatic logic [7:0] msg_sel(input logic [3:0] rnd, input logic [2:0] sub);
        logic [3:0]  row;
        logic [63:0] perm;
        row = (rnd >= 4'd10) ? rnd - 4'd10 : rnd;
        case (row)
            4'd1:    perm = 64'hEA489FD61C02B753;
            4'd2:    perm = 64'hB8C052FDAE367194;
            4'd3:    perm = 64'h7931DCBE265A40F8;
            4'd4:    perm = 64'h905724AFE1BC683D;
            4'd5:    perm = 64'h2C6A0B834D75FE19;
            4'd6:    perm = 64'hC51FED4A0763928B;
            4'd7:    perm = 64'hDB7EC13950F4862A;
            4'd8:    perm = 64'h6FE9B308C2D714A5;
            4'd9:    perm = 64'hA2847615FB9E3CD0;
            default: perm = 64'h0123456789ABCDEF;
        endcase
        return perm[{~sub, 3'b111} -: 8];
    endfunction

    assign w_last_rnd = r_mode ? LP_LAST_B : LP_LAST_S;
    assign w_step_end = (r_hc == LP_HC_LAST);
    assign w_final    = w_step_end && (r_sub == 3'd7) && (r_rnd == w_last_rnd);
    assign w_nsub     = r_sub + 3'd1;
    assign w_nrnd     = (r_sub == 3'd7) ? r_rnd + 4'd1 : r_rnd;

    assign sub_ctr = r_sub;
    assign rnd_ctr = r_rnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hc       <= 2'd0;
            r_sub      <= 3'd0;
            r_rnd      <= 4'd0;
            r_mode     <= 1'b0;
            busy       <= 1'b0;
            step_valid <= 1'b0;
            step_last  <= 1'b0;
            done       <= 1'b0;
            {a_sel, b_sel, c_sel, d_sel} <= 16'h0;
            {m0_sel, m1_sel}             <= 8'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state    <= S_RUN;
                        r_mode     <= mode;
                        r_hc       <= 2'd0;
                        r_sub      <= 3'd0;
                        r_rnd      <= 4'd0;
                        busy       <= 1'b1;
                        step_valid <= 1'b1;
                        step_last  <= (LP_HC_LAST == 2'd0);
                        {a_sel, b_sel, c_sel, d_sel} <= vec_sel(3'd0);
                        {m0_sel, m1_sel}             <= msg_sel(4'd0, 3'd0);
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (!w_step_end) begin
                            r_hc      <= r_hc + 2'd1;
                            step_last <= ((r_hc + 2'd1) == LP_HC_LAST);
                        end else if (w_final) begin
                            r_state    <= S_DONE;
                            r_hc       <= 2'd0;
                            r_sub      <= 3'd0;
                            r_rnd      <= 4'd0;
                            step_valid <= 1'b0;
                            step_last  <= 1'b0;
                            done       <= 1'b1;
                            {a_sel, b_sel, c_sel, d_sel} <= 16'h0;
                            {m0_sel, m1_sel}             <= 8'h0;
                        end else begin
                            r_hc      <= 2'd0;
                            r_sub     <= w_nsub;
                            r_rnd     <= w_nrnd;
                            step_last <= (LP_HC_LAST == 2'd0);
                            {a_sel, b_sel, c_sel, d_sel} <= vec_sel(w_nsub);
                            {m0_sel, m1_sel}             <= msg_sel(w_nrnd, w_nsub);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_f_sched_ctl.sv
// Directed self-checking bench for f_sched_ctl: one instance with single-cycle
// G steps, one with three-cycle G steps; expected selectors come from the BLAKE2 sigma table.
module tb_f_sched_ctl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, mode1 = 1'b0, stall1 = 1'b0;
    logic start3 = 1'b0, mode3 = 1'b0, stall3 = 1'b0;

    logic       busy1, sv1, sl1, done1, busy3, sv3, sl3, done3;
    logic [2:0] sub1, sub3;
    logic [3:0] rnd1, rnd3;
    logic [3:0] a1, b1, c1, d1, m01, m11, a3, b3, c3, d3, m03, m13;

    logic [23:0] sel1, sel3;
    logic [34:0] all1;
    assign sel1 = {a1, b1, c1, d1, m01, m11};
    assign sel3 = {a3, b3, c3, d3, m03, m13};
    assign all1 = {busy1, sv1, sl1, done1, sub1, rnd1, sel1};

    int testCount = 0;
    int failCount = 0;
    int busyCnt1 = 0, validCnt1 = 0, doneCnt1 = 0;
    int busyCnt3 = 0, doneCnt3 = 0;
    int bSnap, vSnap, dSnap, doneAt, ticks;

    f_sched_ctl dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .stall(stall1),
        .busy(busy1), .step_valid(sv1), .step_last(sl1), .sub_ctr(sub1), .rnd_ctr(rnd1),
        .a_sel(a1), .b_sel(b1), .c_sel(c1), .d_sel(d1), .m0_sel(m01), .m1_sel(m11),
        .done(done1)
    );

    f_sched_ctl #(.G_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .stall(stall3),
        .busy(busy3), .step_valid(sv3), .step_last(sl3), .sub_ctr(sub3), .rnd_ctr(rnd3),
        .a_sel(a3), .b_sel(b3), .c_sel(c3), .d_sel(d3), .m0_sel(m03), .m1_sel(m13),
        .done(done3)
    );

    always #5 clk = ~clk;

    // Occupancy counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (busy1) busyCnt1++;
        if (sv1)   validCnt1++;
        if (done1) doneCnt1++;
        if (busy3) busyCnt3++;
        if (done3) doneCnt3++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic st1, input logic md1, input logic sl, input logic st3);
        start1 = st1;
        mode1  = md1;
        stall1 = sl;
        start3 = st3;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic waitIdle(input bit useDut3, input int budget, output int dAt, output int n);
        dAt = -1;
        n   = 0;
        while (((useDut3 ? busy3 : busy1) === 1'b1) && n < budget) begin
            applyStimulus(1'b0, mode1, 1'b0, 1'b0);
            n++;
            if ((useDut3 ? done3 : done1) === 1'b1 && dAt < 0) dAt = n;
        end
    endtask

    initial begin
        // Reset and idle
        @(posedge clk);
        #1;
        checkOutput("reset_all1", 40'(all1), 40'h0);
        checkOutput("reset_busy3", 40'({busy3, sv3, done3}), 40'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_all1", 40'(all1), 40'h0);

        // BLAKE2s, one cycle per G step
        bSnap = busyCnt1; vSnap = validCnt1; dSnap = doneCnt1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("s_step0_sel", 40'(sel1), 40'h048C01);
        checkOutput("s_step0_flags", 40'({busy1, sv1, sl1, done1, sub1, rnd1}), 40'b1110_000_0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s_sub1r0_sel", 40'(sel1), 40'h159D23);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s_sub7r0_sel", 40'(sel1), 40'h349EEF);
        checkOutput("s_sub7r0_ctr", 40'({sub1, rnd1}), 40'({3'd7, 4'd0}));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s_sub0r1_sel", 40'(sel1), 40'h048CEA);
        checkOutput("s_sub0r1_ctr", 40'({sub1, rnd1}), 40'({3'd0, 4'd1}));
        repeat (7) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s_sub7r1_sel", 40'(sel1), 40'h349E53);
        waitIdle(1'b0, 200, doneAt, ticks);
        checkOutput("s_timeout", 40'(busy1), 40'h0);
        checkOutput("s_done_cycle", 40'(15 + doneAt), 40'd80);
        checkOutput("s_busy_cycles", 40'(busyCnt1 - bSnap), 40'd81);
        checkOutput("s_valid_cycles", 40'(validCnt1 - vSnap), 40'd80);
        checkOutput("s_done_pulses", 40'(doneCnt1 - dSnap), 40'd1);
        checkOutput("s_after_idle", 40'(all1), 40'h0);

        // BLAKE2b with mode dropped right after the start edge
        bSnap = busyCnt1; vSnap = validCnt1; dSnap = doneCnt1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (79) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("b_sub0r10_sel", 40'(sel1), 40'h048C01);
        checkOutput("b_sub0r10_ctr", 40'({sub1, rnd1}), 40'({3'd0, 4'd10}));
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("b_sub0r11_sel", 40'(sel1), 40'h048CEA);
        checkOutput("b_sub0r11_ctr", 40'({sub1, rnd1}), 40'({3'd0, 4'd11}));
        waitIdle(1'b0, 200, doneAt, ticks);
        checkOutput("b_timeout", 40'(busy1), 40'h0);
        checkOutput("b_done_cycle", 40'(88 + doneAt), 40'd96);
        checkOutput("b_busy_cycles", 40'(busyCnt1 - bSnap), 40'd97);
        checkOutput("b_valid_cycles", 40'(validCnt1 - vSnap), 40'd96);
        checkOutput("b_done_pulses", 40'(doneCnt1 - dSnap), 40'd1);

        // BLAKE2s with mode raised after start, a 5-cycle stall and stray starts
        bSnap = busyCnt1; vSnap = validCnt1; dSnap = doneCnt1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (19) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("st_pre_stall", 40'(all1), 40'({4'b1110, 3'd3, 4'd2, 24'h37BFFD}));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("st_frozen", 40'(all1), 40'({4'b1110, 3'd3, 4'd2, 24'h37BFFD}));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("st_resume_sel", 40'(sel1), 40'h05AFAE);
        checkOutput("st_resume_ctr", 40'({sub1, rnd1}), 40'({3'd4, 4'd2}));
        repeat (59) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("st_last_step", 40'(all1), 40'({4'b1110, 3'd7, 4'd9, 24'h349ED0}));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("st_done_state", 40'(all1), 40'({4'b1001, 3'd0, 4'd0, 24'h0}));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("st_start_in_done", 40'(all1), 40'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("st_no_restart", 40'(all1), 40'h0);
        checkOutput("st_busy_cycles", 40'(busyCnt1 - bSnap), 40'd86);
        checkOutput("st_valid_cycles", 40'(validCnt1 - vSnap), 40'd85);
        checkOutput("st_done_pulses", 40'(doneCnt1 - dSnap), 40'd1);

        // Three cycles per G step
        bSnap = busyCnt3; dSnap = doneCnt3;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("g3_hc0", 40'({sel3, sv3, sl3}), 40'({24'h048C01, 2'b10}));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("g3_hc1", 40'({sel3, sv3, sl3}), 40'({24'h048C01, 2'b10}));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("g3_hc2", 40'({sel3, sv3, sl3}), 40'({24'h048C01, 2'b11}));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("g3_step1", 40'({sel3, sv3, sl3, sub3, rnd3}), 40'({24'h159D23, 2'b10, 3'd1, 4'd0}));
        waitIdle(1'b1, 1000, doneAt, ticks);
        checkOutput("g3_timeout", 40'(busy3), 40'h0);
        checkOutput("g3_busy_cycles", 40'(busyCnt3 - bSnap), 40'd241);
        checkOutput("g3_done_pulses", 40'(doneCnt3 - dSnap), 40'd1);

        // Asynchronous reset in the middle of a compression
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_pre_busy", 40'(busy1), 40'h1);
        dSnap = doneCnt1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_all1", 40'(all1), 40'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_after_all1", 40'(all1), 40'h0);
        checkOutput("rst_no_done", 40'(doneCnt1 - dSnap), 40'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_restart", 40'(all1), 40'({4'b1110, 3'd0, 4'd0, 24'h048C01}));
        waitIdle(1'b0, 200, doneAt, ticks);
        checkOutput("rst_restart_timeout", 40'(busy1), 40'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
